// File: rtl/countdown_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_timer_pkg
//  Purpose  : Shared types and constants for the two-digit BCD countdown timer
//  Revision : 1.0  initial release
// ============================================================================
package countdown_timer_pkg;

  // Width of one BCD digit and the largest legal BCD value
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = DIGIT_W'(9);

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Saturate an out-of-range preset nibble to the largest BCD digit
  function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage : countdown_timer_pkg
`default_nettype wire

// File: rtl/countdown_timer_if.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_timer_if
//  Purpose  : Control/status bundle between a timer client and the timer
//  Revision : 1.0  initial release
// ============================================================================
interface countdown_timer_if;
  import countdown_timer_pkg::*;

  // Client -> timer
  logic               tick;
  logic               load;
  logic [DIGIT_W-1:0] preset_tens;
  logic [DIGIT_W-1:0] preset_ones;
  logic               start;
  logic               pause;

  // Timer -> client
  logic [DIGIT_W-1:0] tens;
  logic [DIGIT_W-1:0] ones;
  logic               running;
  logic               zero;
  logic               done;

  // Client side
  modport master (
    output tick, load, preset_tens, preset_ones, start, pause,
    input  tens, ones, running, zero, done
  );

  // Timer side
  modport slave (
    input  tick, load, preset_tens, preset_ones, start, pause,
    output tens, ones, running, zero, done
  );

endinterface : countdown_timer_if
`default_nettype wire

// File: rtl/countdown_timer_digit.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_down_digit
//  Purpose  : One loadable BCD down-counting digit with borrow output
//  Revision : 1.0  initial release
// ============================================================================
module bcd_down_digit
  import countdown_timer_pkg::*;
(
  input  logic               clk,
  input  logic               init,
  input  logic               en,
  input  logic               load,
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q,
  output logic               borrow_out
);

  logic [DIGIT_W-1:0] r_q;

  // Digit register: reset, then load, then decrement with 0 -> 9 wrap
  always_ff @(posedge clk) begin
    if (init) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end else if (en) begin
      r_q <= (r_q == '0) ? BCD_MAX : (r_q - DIGIT_W'(1));
    end
  end

  assign q = r_q;

  // A decrement request arriving at 0 must be passed on to the next digit
  assign borrow_out = en && (r_q == '0);

endmodule : bcd_down_digit
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_timer
//  Purpose  : Two-digit BCD countdown timer with start/pause/load control
//  Revision : 1.0  initial release
// ============================================================================
module countdown_timer
  import countdown_timer_pkg::*;
(
  input  logic              clk,
  input  logic              init,
  countdown_timer_if.slave  bus
);

  state_t             r_state;
  logic               r_running;
  logic               r_done;

  logic [DIGIT_W-1:0] w_tens;
  logic [DIGIT_W-1:0] w_ones;
  logic [DIGIT_W-1:0] w_preset_tens;
  logic [DIGIT_W-1:0] w_preset_ones;
  logic               w_zero;
  logic               w_dec;
  logic               w_ones_borrow;
  logic               w_tens_borrow_unused;
  logic               w_last_count;

  // Out-of-range presets are saturated before they reach the digits
  assign w_preset_tens = bcd_clamp(bus.preset_tens);
  assign w_preset_ones = bcd_clamp(bus.preset_ones);

  assign w_zero = (w_tens == '0) && (w_ones == '0);

  // One count per tick, only while running; load and pause both suppress it,
  // and the zero guard keeps the tens digit from ever wrapping
  assign w_dec = (r_state == ST_RUN) && bus.tick && !bus.load && !bus.pause && !w_zero;

  // This decrement takes the count from 01 to 00
  assign w_last_count = w_dec && (w_tens == '0) && (w_ones == DIGIT_W'(1));

  // Controller: state plus registered running/done flags
  always_ff @(posedge clk) begin
    if (init) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.load) begin
        r_state   <= ST_IDLE;
        r_running <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.start && !w_zero) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (bus.pause) begin
              r_state   <= ST_PAUSED;
              r_running <= 1'b0;
            end else if (w_last_count) begin
              r_state   <= ST_DONE;
              r_running <= 1'b0;
              r_done    <= 1'b1;
            end
          end
          ST_PAUSED: begin
            if (!bus.pause && bus.start) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
          ST_DONE: begin
            if (!bus.start) begin
              r_state   <= ST_IDLE;
              r_running <= 1'b0;
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  bcd_down_digit u_ones (
    .clk        (clk),
    .init       (init),
    .en         (w_dec),
    .load       (bus.load),
    .d          (w_preset_ones),
    .q          (w_ones),
    .borrow_out (w_ones_borrow)
  );

  // Tens only moves when the ones digit wraps
  bcd_down_digit u_tens (
    .clk        (clk),
    .init       (init),
    .en         (w_ones_borrow),
    .load       (bus.load),
    .d          (w_preset_tens),
    .q          (w_tens),
    .borrow_out (w_tens_borrow_unused)
  );

  assign bus.tens    = w_tens;
  assign bus.ones    = w_ones;
  assign bus.zero    = w_zero;
  assign bus.running = r_running;
  assign bus.done    = r_done;

endmodule : countdown_timer
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_countdown_timer
//  Purpose  : Self-checking bench for the two-digit BCD countdown timer
//  Revision : 1.0  initial release
// ============================================================================
module tb_countdown_timer;

  logic clk;
  logic init;

  countdown_timer_if bus ();

  countdown_timer dut (
    .clk  (clk),
    .init (init),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One stimulus cycle and the outputs expected after its clock edge
  typedef struct {
    string      name;
    logic       i_init;
    logic       i_load;
    logic [3:0] i_pt;
    logic [3:0] i_po;
    logic       i_start;
    logic       i_pause;
    logic       i_tick;
    logic [3:0] e_tens;
    logic [3:0] e_ones;
    logic       e_run;
    logic       e_zero;
    logic       e_done;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int done_seen = 0;

  function automatic vec_t mk(string nm, logic ini, logic ld, logic [3:0] pt, logic [3:0] po,
                              logic st, logic ps, logic tk, logic [3:0] et, logic [3:0] eo,
                              logic er, logic ez, logic ed);
    vec_t v;
    v.name = nm; v.i_init = ini; v.i_load = ld; v.i_pt = pt; v.i_po = po;
    v.i_start = st; v.i_pause = ps; v.i_tick = tk;
    v.e_tens = et; v.e_ones = eo; v.e_run = er; v.e_zero = ez; v.e_done = ed;
    return v;
  endfunction

  // Drive one cycle, queue its expectation, then pop and compare after the edge
  task automatic apply(input vec_t v);
    vec_t e;
    init            = v.i_init;
    bus.load        = v.i_load;
    bus.preset_tens = v.i_pt;
    bus.preset_ones = v.i_po;
    bus.start       = v.i_start;
    bus.pause       = v.i_pause;
    bus.tick        = v.i_tick;
    sb.push_back(v);
    @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      e = sb.pop_front();
      if (bus.done) done_seen++;
      if (bus.tens !== e.e_tens || bus.ones !== e.e_ones || bus.running !== e.e_run ||
          bus.zero !== e.e_zero || bus.done !== e.e_done) begin
        n_fail++;
        $display("FAIL %s: got t=%0d o=%0d run=%b zero=%b done=%b, want t=%0d o=%0d run=%b zero=%b done=%b",
                 e.name, bus.tens, bus.ones, bus.running, bus.zero, bus.done,
                 e.e_tens, e.e_ones, e.e_run, e.e_zero, e.e_done);
      end
    end
  endtask

  // Shorthand for a normal (no init, no load) cycle with expected count value
  task automatic run_cyc(input string nm, input logic st, input logic ps, input logic tk,
                         input int val, input logic er, input logic ed);
    apply(mk(nm, 1'b0, 1'b0, 4'd0, 4'd0, st, ps, tk, 4'(val / 10), 4'(val % 10),
             er, (val == 0), ed));
  endtask

  task automatic load_cyc(input string nm, input logic [3:0] pt, input logic [3:0] po,
                          input logic [3:0] et, input logic [3:0] eo);
    apply(mk(nm, 1'b0, 1'b1, pt, po, 1'b0, 1'b0, 1'b0, et, eo, 1'b0,
             (et == 4'd0 && eo == 4'd0), 1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    init = 1'b1; bus.load = 1'b0; bus.preset_tens = '0; bus.preset_ones = '0;
    bus.start = 1'b0; bus.pause = 1'b0; bus.tick = 1'b0;
    @(posedge clk); #1;

    //            name           ini ld  pt  po  st ps tk  et  eo  run zero done
    vecs.push_back(mk("reset",     1, 0, 0,  0,  0, 0, 0,  0,  0,  0,  1,  0));
    vecs.push_back(mk("load37",    0, 1, 3,  7,  0, 0, 0,  3,  7,  0,  0,  0));
    vecs.push_back(mk("start37",   0, 0, 0,  0,  1, 0, 0,  3,  7,  1,  0,  0));
    vecs.push_back(mk("tick36",    0, 0, 0,  0,  1, 0, 1,  3,  6,  1,  0,  0));
    vecs.push_back(mk("init_run",  1, 1, 5,  5,  1, 1, 1,  0,  0,  0,  1,  0));
    vecs.push_back(mk("clampAF",   0, 1, 12, 15, 0, 0, 0,  9,  9,  0,  0,  0));
    vecs.push_back(mk("load00",    0, 1, 0,  0,  0, 0, 0,  0,  0,  0,  1,  0));
    vecs.push_back(mk("start00",   0, 0, 0,  0,  1, 0, 0,  0,  0,  0,  1,  0));
    vecs.push_back(mk("start00tk", 0, 0, 0,  0,  1, 0, 1,  0,  0,  0,  1,  0));
    vecs.push_back(mk("load50",    0, 1, 5,  0,  0, 0, 0,  5,  0,  0,  0,  0));
    vecs.push_back(mk("start50",   0, 0, 0,  0,  1, 0, 0,  5,  0,  1,  0,  0));
    vecs.push_back(mk("ld_tick50", 0, 1, 5,  0,  1, 0, 1,  5,  0,  0,  0,  0));
    vecs.push_back(mk("idle_tick", 0, 0, 0,  0,  0, 0, 1,  5,  0,  0,  0,  0));
    vecs.push_back(mk("restart50", 0, 0, 0,  0,  1, 0, 0,  5,  0,  1,  0,  0));
    vecs.push_back(mk("tick49",    0, 0, 0,  0,  1, 0, 1,  4,  9,  1,  0,  0));
    vecs.push_back(mk("pause_tk",  0, 0, 0,  0,  1, 1, 1,  4,  9,  0,  0,  0));
    vecs.push_back(mk("pau_nostr", 0, 0, 0,  0,  0, 0, 1,  4,  9,  0,  0,  0));
    vecs.push_back(mk("resume",    0, 0, 0,  0,  1, 0, 0,  4,  9,  1,  0,  0));
    vecs.push_back(mk("tick48",    0, 0, 0,  0,  1, 0, 1,  4,  8,  1,  0,  0));

    foreach (vecs[i]) apply(vecs[i]);

    // Full 23-tick run down to 00 with a single done pulse
    apply(mk("seqA_init", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    load_cyc("seqA_load", 4'd2, 4'd3, 4'd2, 4'd3);
    run_cyc("seqA_start", 1, 0, 0, 23, 1, 0);
    done_seen = 0;
    for (int i = 1; i <= 23; i++) begin
      run_cyc($sformatf("seqA_tick%0d", i), 1, 0, 1, 23 - i, (i < 23), (i == 23));
      run_cyc($sformatf("seqA_gap%0d", i), 1, 0, 0, 23 - i, (i < 23), 1'b0);
    end
    run_cyc("seqA_done_tick", 1, 0, 1, 0, 0, 0);
    run_cyc("seqA_to_idle", 0, 0, 0, 0, 0, 0);
    run_cyc("seqA_restart0", 1, 0, 1, 0, 0, 0);
    n_cmp++;
    if (done_seen != 1) begin
      n_fail++;
      $display("FAIL seqA_done_count: got %0d pulses, want 1", done_seen);
    end

    // 10 -> 09: ones wraps and tens borrows on the same edge
    load_cyc("seqB_load", 4'd1, 4'd0, 4'd1, 4'd0);
    run_cyc("seqB_start", 1, 0, 0, 10, 1, 0);
    run_cyc("seqB_tick", 1, 0, 1, 9, 1, 0);

    // Pause holds the count through ticks, then the run resumes to 00
    load_cyc("seqC_load", 4'd0, 4'd5, 4'd0, 4'd5);
    run_cyc("seqC_start", 1, 0, 0, 5, 1, 0);
    run_cyc("seqC_t04", 1, 0, 1, 4, 1, 0);
    run_cyc("seqC_t03", 1, 0, 1, 3, 1, 0);
    for (int i = 0; i < 3; i++)
      run_cyc($sformatf("seqC_pause%0d", i), 1, 1, 1, 3, 0, 0);
    run_cyc("seqC_resume", 1, 0, 0, 3, 1, 0);
    run_cyc("seqC_t02", 1, 0, 1, 2, 1, 0);
    run_cyc("seqC_t01", 1, 0, 1, 1, 1, 0);
    run_cyc("seqC_t00", 1, 0, 1, 0, 0, 1);
    run_cyc("seqC_after", 1, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_countdown_timer
`default_nettype wire
